// File: rtl/krnl_cbc_axi_ctrl_master_pkg.sv
// Shared CTRL register map and control bit positions of the CBC kernel,
// plus the master's sequencing constants and state encoding.
package krnl_cbc_axi_ctrl_master_pkg;

  localparam logic [11:0] CTRL_ADDR_AP_CTRL   = 12'h000;
  localparam logic [11:0] CTRL_ADDR_MODE      = 12'h010;
  localparam logic [11:0] CTRL_ADDR_IV_W3     = 12'h018;
  localparam logic [11:0] CTRL_ADDR_IV_W2     = 12'h020;
  localparam logic [11:0] CTRL_ADDR_IV_W1     = 12'h028;
  localparam logic [11:0] CTRL_ADDR_IV_W0     = 12'h030;
  localparam logic [11:0] CTRL_ADDR_WORDS_NUM = 12'h038;
  localparam logic [11:0] CTRL_ADDR_SRC_LO    = 12'h040;
  localparam logic [11:0] CTRL_ADDR_SRC_HI    = 12'h044;
  localparam logic [11:0] CTRL_ADDR_DST_LO    = 12'h048;
  localparam logic [11:0] CTRL_ADDR_DST_HI    = 12'h04C;
  localparam logic [11:0] CTRL_ADDR_CBC_MODE  = 12'h050;

  localparam int unsigned CTRL_BIT_START    = 32'd0;
  localparam int unsigned CTRL_BIT_DONE     = 32'd1;
  localparam int unsigned CTRL_BIT_IDLE     = 32'd2;
  localparam int unsigned CTRL_BIT_READY    = 32'd3;
  localparam int unsigned CTRL_BIT_CONTINUE = 32'd4;

  localparam logic [3:0] SEQ_IDX_START    = 4'd11;
  localparam logic [3:0] SEQ_IDX_CONTINUE = 4'd12;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WR_REQ        = 3'd1,
    WR_RESP       = 3'd2,
    POLL_GAP_WAIT = 3'd3,
    RD_REQ        = 3'd4,
    RD_RESP       = 3'd5,
    FIN           = 3'd6
  } ctrl_state_e;

  function automatic logic [31:0] ctrl_mask(input int unsigned bit_pos);
    ctrl_mask = 32'd1 << bit_pos;
  endfunction

endpackage

// File: rtl/krnl_cbc_axi_ctrl_master.sv
// AXI4-Lite master that programs the CBC kernel CTRL block, pulses ap_start,
// polls ap_done and acknowledges with ap_continue; one transaction at a time.
module krnl_cbc_axi_ctrl_master
  import krnl_cbc_axi_ctrl_master_pkg::*;
#(
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        mode,
  input  logic        cbc_mode,
  input  logic [31:0] iv_w3,
  input  logic [31:0] iv_w2,
  input  logic [31:0] iv_w1,
  input  logic [31:0] iv_w0,
  input  logic [31:0] words_num,
  input  logic [63:0] src_addr,
  input  logic [63:0] dest_addr,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [11:0] M_AWADDR,
  output logic        M_AWVALID,
  input  logic        M_AWREADY,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_WSTRB,
  output logic        M_WVALID,
  input  logic        M_WREADY,
  input  logic [1:0]  M_BRESP,
  input  logic        M_BVALID,
  output logic        M_BREADY,
  output logic [11:0] M_ARADDR,
  output logic        M_ARVALID,
  input  logic        M_ARREADY,
  input  logic [31:0] M_RDATA,
  input  logic [1:0]  M_RRESP,
  input  logic        M_RVALID,
  output logic        M_RREADY
);

  ctrl_state_e r_state, w_state_nxt;
  logic [3:0]  r_idx;
  logic [31:0] r_gap_cnt, r_rd_cnt, w_rd_cnt_inc;
  logic        r_aw_done, r_w_done, r_err;
  logic        r_mode, r_cbc_mode;
  logic [31:0] r_iv_w3, r_iv_w2, r_iv_w1, r_iv_w0, r_words_num;
  logic [63:0] r_src_addr, r_dest_addr;
  logic [11:0] w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_accept, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_wr_both;
  logic        w_set_err, w_ap_done;
  logic        w_unused_rdata;

  assign w_accept     = (r_state == IDLE) && cmd_valid;
  assign w_aw_hs      = M_AWVALID && M_AWREADY;
  assign w_w_hs       = M_WVALID && M_WREADY;
  assign w_b_hs       = M_BVALID && M_BREADY;
  assign w_ar_hs      = M_ARVALID && M_ARREADY;
  assign w_r_hs       = M_RVALID && M_RREADY;
  assign w_wr_both    = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
  assign w_rd_cnt_inc = r_rd_cnt + 32'd1;
  assign w_ap_done    = M_RDATA[CTRL_BIT_DONE];
  // Only the done bit of the CTRL word is meaningful to this master.
  assign w_unused_rdata = ^{M_RDATA[31:2], M_RDATA[0]};

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign err       = r_err;
  assign M_AWVALID = (r_state == WR_REQ) && !r_aw_done;
  assign M_WVALID  = (r_state == WR_REQ) && !r_w_done;
  assign M_AWADDR  = w_wr_addr;
  assign M_WDATA   = w_wr_data;
  assign M_WSTRB   = 4'hF;
  assign M_BREADY  = (r_state == WR_RESP);
  assign M_ARVALID = (r_state == RD_REQ);
  assign M_ARADDR  = CTRL_ADDR_AP_CTRL;
  assign M_RREADY  = (r_state == RD_RESP);

  // Write sequence: register address and data for the current index.
  always_comb begin
    w_wr_addr = CTRL_ADDR_AP_CTRL;
    w_wr_data = 32'h0000_0000;
    case (r_idx)
      4'd0:    begin w_wr_addr = CTRL_ADDR_MODE;      w_wr_data = {31'b0, r_mode};       end
      4'd1:    begin w_wr_addr = CTRL_ADDR_CBC_MODE;  w_wr_data = {31'b0, r_cbc_mode};   end
      4'd2:    begin w_wr_addr = CTRL_ADDR_IV_W3;     w_wr_data = r_iv_w3;               end
      4'd3:    begin w_wr_addr = CTRL_ADDR_IV_W2;     w_wr_data = r_iv_w2;               end
      4'd4:    begin w_wr_addr = CTRL_ADDR_IV_W1;     w_wr_data = r_iv_w1;               end
      4'd5:    begin w_wr_addr = CTRL_ADDR_IV_W0;     w_wr_data = r_iv_w0;               end
      4'd6:    begin w_wr_addr = CTRL_ADDR_WORDS_NUM; w_wr_data = r_words_num;           end
      4'd7:    begin w_wr_addr = CTRL_ADDR_SRC_LO;    w_wr_data = r_src_addr[31:0];      end
      4'd8:    begin w_wr_addr = CTRL_ADDR_SRC_HI;    w_wr_data = r_src_addr[63:32];     end
      4'd9:    begin w_wr_addr = CTRL_ADDR_DST_LO;    w_wr_data = r_dest_addr[31:0];     end
      4'd10:   begin w_wr_addr = CTRL_ADDR_DST_HI;    w_wr_data = r_dest_addr[63:32];    end
      4'd11:   begin w_wr_addr = CTRL_ADDR_AP_CTRL;   w_wr_data = ctrl_mask(CTRL_BIT_START); end
      4'd12:   begin w_wr_addr = CTRL_ADDR_AP_CTRL;   w_wr_data = ctrl_mask(CTRL_BIT_CONTINUE); end
      default: begin w_wr_addr = CTRL_ADDR_AP_CTRL;   w_wr_data = 32'h0000_0000;         end
    endcase
  end

  // Next-state decode; any non-OKAY response or poll exhaustion ends the job with err.
  always_comb begin
    w_state_nxt = r_state;
    w_set_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) w_state_nxt = WR_REQ;
        else           w_state_nxt = IDLE;
      end
      WR_REQ: begin
        if (w_wr_both) w_state_nxt = WR_RESP;
        else           w_state_nxt = WR_REQ;
      end
      WR_RESP: begin
        if (!w_b_hs) begin
          w_state_nxt = WR_RESP;
        end else if (M_BRESP != AXI_RESP_OKAY) begin
          w_state_nxt = FIN;
          w_set_err   = 1'b1;
        end else if (r_idx == SEQ_IDX_CONTINUE) begin
          w_state_nxt = FIN;
        end else if (r_idx == SEQ_IDX_START) begin
          w_state_nxt = POLL_GAP_WAIT;
        end else begin
          w_state_nxt = WR_REQ;
        end
      end
      POLL_GAP_WAIT: begin
        if (r_gap_cnt + 32'd1 >= POLL_GAP) w_state_nxt = RD_REQ;
        else                               w_state_nxt = POLL_GAP_WAIT;
      end
      RD_REQ: begin
        if (w_ar_hs) w_state_nxt = RD_RESP;
        else         w_state_nxt = RD_REQ;
      end
      RD_RESP: begin
        if (!w_r_hs) begin
          w_state_nxt = RD_RESP;
        end else if (M_RRESP != AXI_RESP_OKAY) begin
          w_state_nxt = FIN;
          w_set_err   = 1'b1;
        end else if (w_ap_done) begin
          w_state_nxt = WR_REQ;
        end else if (w_rd_cnt_inc >= POLL_LIMIT) begin
          w_state_nxt = FIN;
          w_set_err   = 1'b1;
        end else begin
          w_state_nxt = POLL_GAP_WAIT;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Job latch, sequence index, handshake tracking, counters and error flag.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_idx       <= 4'd0;
      r_gap_cnt   <= 32'd0;
      r_rd_cnt    <= 32'd0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_err       <= 1'b0;
      r_mode      <= 1'b0;
      r_cbc_mode  <= 1'b0;
      r_iv_w3     <= 32'd0;
      r_iv_w2     <= 32'd0;
      r_iv_w1     <= 32'd0;
      r_iv_w0     <= 32'd0;
      r_words_num <= 32'd0;
      r_src_addr  <= 64'd0;
      r_dest_addr <= 64'd0;
    end else begin
      if (w_accept) begin
        r_mode      <= mode;
        r_cbc_mode  <= cbc_mode;
        r_iv_w3     <= iv_w3;
        r_iv_w2     <= iv_w2;
        r_iv_w1     <= iv_w1;
        r_iv_w0     <= iv_w0;
        r_words_num <= words_num;
        r_src_addr  <= src_addr;
        r_dest_addr <= dest_addr;
        r_idx       <= 4'd0;
        r_rd_cnt    <= 32'd0;
        r_err       <= 1'b0;
      end else begin
        if (w_b_hs && (M_BRESP == AXI_RESP_OKAY) && (r_idx != SEQ_IDX_CONTINUE))
          r_idx <= r_idx + 4'd1;
        else if (w_r_hs && (M_RRESP == AXI_RESP_OKAY) && w_ap_done)
          r_idx <= SEQ_IDX_CONTINUE;
        if (w_r_hs)    r_rd_cnt <= w_rd_cnt_inc;
        if (w_set_err) r_err    <= 1'b1;
      end
      // Each channel's valid drops after its own handshake until both are done.
      r_aw_done <= (r_state == WR_REQ) && !w_wr_both && (r_aw_done || w_aw_hs);
      r_w_done  <= (r_state == WR_REQ) && !w_wr_both && (r_w_done || w_w_hs);
      r_gap_cnt <= (r_state == POLL_GAP_WAIT) ? r_gap_cnt + 32'd1 : 32'd0;
    end
  end

endmodule

// File: tb/tb_krnl_cbc_axi_ctrl_master.sv
// Bench for krnl_cbc_axi_ctrl_master: reactive AXI4-Lite slave model with
// programmable stalls/errors and a queue of expected CTRL writes.
module tb_krnl_cbc_axi_ctrl_master;

  localparam int unsigned TB_POLL_GAP   = 16;
  localparam int unsigned TB_POLL_LIMIT = 6;

  typedef struct packed {
    logic        mode;
    logic        cbc;
    logic [31:0] iv3, iv2, iv1, iv0, words;
    logic [63:0] src, dst;
  } job_t;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, mode, cbc_mode;
  logic [31:0] iv_w3, iv_w2, iv_w1, iv_w0, words_num;
  logic [63:0] src_addr, dest_addr;
  logic        done, err, busy;
  logic [11:0] M_AWADDR, M_ARADDR;
  logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [31:0] M_WDATA, M_RDATA;
  logic [3:0]  M_WSTRB;
  logic [1:0]  M_BRESP, M_RRESP;

  always #5 ACLK = ~ACLK;

  krnl_cbc_axi_ctrl_master #(.POLL_GAP(TB_POLL_GAP), .POLL_LIMIT(TB_POLL_LIMIT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .mode(mode), .cbc_mode(cbc_mode), .iv_w3(iv_w3), .iv_w2(iv_w2), .iv_w1(iv_w1),
    .iv_w0(iv_w0), .words_num(words_num), .src_addr(src_addr), .dest_addr(dest_addr),
    .done(done), .err(err), .busy(busy),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  // Slave configuration, written only by the stimulus process.
  logic alt_dly = 1'b0;
  int   bad_b_idx = -1;
  int   done_on_read = 0;
  int   bad_r_idx = 0;

  // Slave state.
  int          cyc = 0;
  int          wr_num, rd_num, dup_cnt, overlap_cnt, aw_cnt, w_cnt;
  int          last_ar_cyc, b_cyc, done_cyc;
  int          min_ar_gap = 1000000;
  int          aw_dly, w_dly;
  logic        have_aw, have_w, bvalid_r, rvalid_r;
  logic [11:0] cap_addr;
  logic [31:0] cap_data, rdata_r;
  logic [3:0]  cap_strb;
  logic [1:0]  bresp_r, rresp_r;
  logic        aw_hs, w_hs, wr_complete;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int k, input job_t j);
    logic [11:0] a;
    logic [31:0] d;
    case (k)
      0:  begin a = 12'h010; d = {31'b0, j.mode}; end
      1:  begin a = 12'h050; d = {31'b0, j.cbc};  end
      2:  begin a = 12'h018; d = j.iv3;           end
      3:  begin a = 12'h020; d = j.iv2;           end
      4:  begin a = 12'h028; d = j.iv1;           end
      5:  begin a = 12'h030; d = j.iv0;           end
      6:  begin a = 12'h038; d = j.words;         end
      7:  begin a = 12'h040; d = j.src[31:0];     end
      8:  begin a = 12'h044; d = j.src[63:32];    end
      9:  begin a = 12'h048; d = j.dst[31:0];     end
      10: begin a = 12'h04C; d = j.dst[63:32];    end
      11: begin a = 12'h000; d = 32'h0000_0001;   end
      12: begin a = 12'h000; d = 32'h0000_0010;   end
      default: begin a = 12'h000; d = 32'h0;      end
    endcase
    return {16'h0, 4'hF, a, d};
  endfunction

  always_comb begin
    aw_dly = (alt_dly && (wr_num % 2 == 0)) ? 0 : 0;
    w_dly  = 0;
    if (alt_dly) begin
      aw_dly = (wr_num % 2 == 1) ? 3 : 0;
      w_dly  = (wr_num % 2 == 1) ? 0 : 3;
    end
  end

  assign M_AWREADY   = M_AWVALID && (aw_cnt >= aw_dly);
  assign M_WREADY    = M_WVALID && (w_cnt >= w_dly);
  assign M_ARREADY   = M_ARVALID;
  assign M_BVALID    = bvalid_r;
  assign M_BRESP     = bresp_r;
  assign M_RVALID    = rvalid_r;
  assign M_RDATA     = rdata_r;
  assign M_RRESP     = rresp_r;
  assign aw_hs       = M_AWVALID && M_AWREADY;
  assign w_hs        = M_WVALID && M_WREADY;
  assign wr_complete = (have_aw || aw_hs) && (have_w || w_hs) && (aw_hs || w_hs);

  always @(posedge ACLK) cyc <= cyc + 1;

  // Slave responder and protocol monitors.
  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_num <= 0; rd_num <= 0; dup_cnt <= 0; overlap_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      have_aw <= 1'b0; have_w <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      bresp_r <= 2'b00; rresp_r <= 2'b00; rdata_r <= 32'h0;
      cap_addr <= 12'h0; cap_data <= 32'h0; cap_strb <= 4'h0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        wr_num <= 0; rd_num <= 0; min_ar_gap <= 1000000;
      end
      if (aw_hs) begin
        if (have_aw) dup_cnt <= dup_cnt + 1;
        have_aw <= 1'b1; cap_addr <= M_AWADDR; aw_cnt <= 0;
      end else if (M_AWVALID) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        if (have_w) dup_cnt <= dup_cnt + 1;
        have_w <= 1'b1; cap_data <= M_WDATA; cap_strb <= M_WSTRB; w_cnt <= 0;
      end else if (M_WVALID) w_cnt <= w_cnt + 1;
      if (wr_complete) begin
        have_aw <= 1'b0; have_w <= 1'b0; bvalid_r <= 1'b1;
        bresp_r <= (wr_num == bad_b_idx) ? 2'b10 : 2'b00;
        wr_num  <= wr_num + 1;
      end else if (bvalid_r && M_BREADY) begin
        bvalid_r <= 1'b0; b_cyc <= cyc;
      end
      if (M_ARVALID && M_ARREADY) begin
        rvalid_r <= 1'b1;
        rd_num   <= rd_num + 1;
        rdata_r  <= (rd_num + 1 == done_on_read) ? 32'hFFFF_FFFF : 32'hFFFF_FFFD;
        rresp_r  <= (rd_num + 1 == bad_r_idx) ? 2'b10 : 2'b00;
        if (rd_num > 0 && (cyc - last_ar_cyc) < min_ar_gap) min_ar_gap <= cyc - last_ar_cyc;
        last_ar_cyc <= cyc;
      end else if (rvalid_r && M_RREADY) rvalid_r <= 1'b0;
      if ((M_AWVALID || M_WVALID) && M_ARVALID) overlap_cnt <= overlap_cnt + 1;
      if (done) done_cyc <= cyc;
    end
  end

  // Scoreboard: each completed write is matched against the next expected one.
  always @(posedge ACLK) begin
    if (ARESETn && wr_complete) begin
      if (exp_q.size() == 0)
        check_val("wr_extra", 64'(exp_q.size()), 64'd1);
      else
        check_val("wr_seq", {16'h0, (w_hs ? M_WSTRB : cap_strb), (aw_hs ? M_AWADDR : cap_addr),
                             (w_hs ? M_WDATA : cap_data)}, exp_q.pop_front());
    end
  end

  task automatic start_job(input job_t j, input int n_wr);
    for (int k = 0; k < n_wr; k++) exp_q.push_back(exp_word(k, j));
    @(negedge ACLK);
    mode = j.mode; cbc_mode = j.cbc; iv_w3 = j.iv3; iv_w2 = j.iv2; iv_w1 = j.iv1;
    iv_w0 = j.iv0; words_num = j.words; src_addr = j.src; dest_addr = j.dst;
    cmd_valid = 1'b1;
    for (int t = 0; t < 20 && !cmd_ready; t++) @(negedge ACLK);
    check_val("cmd_ready_accept", 64'(cmd_ready), 64'd1);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    mode = ~j.mode; cbc_mode = ~j.cbc; iv_w3 = $urandom(); iv_w2 = $urandom();
    iv_w1 = $urandom(); iv_w0 = $urandom(); words_num = $urandom();
    src_addr = {$urandom(), $urandom()}; dest_addr = {$urandom(), $urandom()};
    check_val("accept_state", {61'h0, busy, cmd_ready, err}, 64'b100);
  endtask

  task automatic wait_done(input string tag, input logic exp_err, input int exp_reads);
    for (int t = 0; t < 3000 && !done; t++) @(negedge ACLK);
    check_val({tag, "_done"}, 64'(done), 64'd1);
    check_val({tag, "_err"}, 64'(err), 64'(exp_err));
    @(negedge ACLK);
    check_val({tag, "_fin_one_cycle"}, {61'h0, done, busy, cmd_ready}, 64'b001);
    check_val({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check_val({tag, "_reads"}, 64'(rd_num), 64'(exp_reads));
    check_val({tag, "_dup_overlap"}, {32'(dup_cnt), 32'(overlap_cnt)}, 64'd0);
    exp_q.delete();
  endtask

  job_t ja, jb, jc, jd, je, jf;
  logic found;

  initial begin
    ARESETn = 1'b0; cmd_valid = 1'b0; mode = 1'b0; cbc_mode = 1'b0;
    iv_w3 = 32'h0; iv_w2 = 32'h0; iv_w1 = 32'h0; iv_w0 = 32'h0; words_num = 32'h0;
    src_addr = 64'h0; dest_addr = 64'h0;
    repeat (3) @(negedge ACLK);
    check_val("reset_outputs", {56'h0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY,
                                done, err, busy}, 64'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_val("reset_cmd_ready", 64'(cmd_ready), 64'd1);

    ja = '{mode: 1'b1, cbc: 1'b1, iv3: 32'h0F0E0D0C, iv2: 32'h0B0A0908, iv1: 32'h07060504,
           iv0: 32'h03020100, words: 32'h40, src: 64'h0000_0012_3456_7000,
           dst: 64'h0000_00AB_CDEF_8000};
    done_on_read = 1;
    start_job(ja, 13);
    wait_done("basic", 1'b0, 1);

    jb = '{mode: 1'b0, cbc: 1'b1, iv3: 32'hDEADBEEF, iv2: 32'h01234567, iv1: 32'h89ABCDEF,
           iv0: 32'hCAFEF00D, words: 32'h100, src: 64'h8000_0001_0000_0040,
           dst: 64'h7FFF_FFFE_FFFF_FFC0};
    alt_dly = 1'b1; done_on_read = 5;
    start_job(jb, 13);
    wait_done("stall_poll5", 1'b0, 5);
    check_val("poll_spacing", 64'(min_ar_gap >= int'(TB_POLL_GAP) + 1), 64'd1);
    alt_dly = 1'b0;

    jc = '{mode: 1'b1, cbc: 1'b0, iv3: 32'h11111111, iv2: 32'h22222222, iv1: 32'h33333333,
           iv0: 32'h44444444, words: 32'h8, src: 64'h1000, dst: 64'h2000};
    done_on_read = 0;
    start_job(jc, 12);
    wait_done("poll_timeout", 1'b1, int'(TB_POLL_LIMIT));

    jd = '{mode: 1'b0, cbc: 1'b0, iv3: 32'hA5A5A5A5, iv2: 32'h5A5A5A5A, iv1: 32'hFFFF0000,
           iv0: 32'h0000FFFF, words: 32'h20, src: 64'hAAAA_BBBB_CCCC_DDDD,
           dst: 64'h1111_2222_3333_4444};
    bad_b_idx = 7; done_on_read = 1;
    start_job(jd, 8);
    wait_done("bresp_err", 1'b1, 0);
    check_val("bresp_done_latency", 64'(done_cyc - b_cyc), 64'd1);
    bad_b_idx = -1;

    je = '{mode: 1'b1, cbc: 1'b1, iv3: 32'h0, iv2: 32'h0, iv1: 32'h0, iv0: 32'h0,
           words: 32'h0, src: 64'h0, dst: 64'h0};
    bad_r_idx = 1;
    start_job(je, 12);
    wait_done("rresp_err_words0", 1'b1, 1);
    bad_r_idx = 0;

    start_job(ja, 13);
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      if (wr_num == 4 && M_WVALID) found = 1'b1;
      else @(negedge ACLK);
    end
    check_val("reset_point_reached", 64'(found), 64'd1);
    ARESETn = 1'b0;
    #1;
    check_val("midreset_outputs", {56'h0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY,
                                   done, err, busy}, 64'h0);
    exp_q.delete();
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_val("post_reset_ready", {62'h0, cmd_ready, busy}, 64'b10);

    jf = '{mode: 1'b0, cbc: 1'b1, iv3: 32'h13579BDF, iv2: 32'h2468ACE0, iv1: 32'hFEDCBA98,
           iv0: 32'h76543210, words: 32'h1, src: 64'h0000_0000_0000_0100,
           dst: 64'hFFFF_FFFF_FFFF_FF00};
    done_on_read = 2;
    start_job(jf, 13);
    wait_done("after_reset", 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
